// File: rtl/ntt_ctrl_pkg.sv
// Shared types for the NTT sequencer: FSM states and transform direction.
package ntt_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      SCALE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef enum logic {
      FWD = 1'b0,
      INV = 1'b1
   } mode_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly-pair and twiddle address generator for one NTT stage.
// In scale mode it walks adjacent coefficient pairs with no twiddle.
module ntt_addr_gen #(
   parameter int N          = 256,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic [$clog2(N)-1:0]  stage,
   input  logic [ADDR_WIDTH-1:0] b,
   input  logic                  scale,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [ADDR_WIDTH-1:0] twiddle_addr
);

   localparam int LOGN = $clog2(N);

   logic [ADDR_WIDTH-1:0] half;
   logic [ADDR_WIDTH-1:0] group;
   logic [ADDR_WIDTH-1:0] pos;
   logic [ADDR_WIDTH-1:0] base;
   logic [LOGN-1:0]       tw_sh;

   // Split b into group/position for the stage span, then form the pair and twiddle index.
   always_comb begin
      half  = ADDR_WIDTH'(1) << stage;
      group = b >> stage;
      pos   = b & (half - ADDR_WIDTH'(1));
      base  = (group << stage) << 1;
      tw_sh = LOGN'(LOGN - 1) - stage;
      if (scale) begin
         addr_a       = b << 1;
         addr_b       = (b << 1) | ADDR_WIDTH'(1);
         twiddle_addr = '0;
      end else begin
         addr_a       = base + pos;
         addr_b       = base + pos + half;
         twiddle_addr = (ADDR_WIDTH'(1) << tw_sh) - ADDR_WIDTH'(1) + group;
      end
   end

endmodule

// File: rtl/ntt_control_cfg.sv
// NTT pass sequencer: walks stages, butterfly pairs and per-pair phases, driving
// RAM/twiddle addresses and strobes. Inverse runs add a final N^-1 scale pass.
module ntt_control_cfg
   import ntt_ctrl_pkg::*;
#(
   parameter int N          = 256,
   parameter int ADDR_WIDTH = $clog2(N),
   parameter int PHASES     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  inverse,
   input  logic                  stall,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   output logic                  ram_re,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] twiddle_addr,
   output logic                  butterfly_valid,
   output logic                  scale_en,
   output logic [$clog2(N)-1:0]  stage_o
);

   localparam int LOGN   = $clog2(N);
   localparam int HALF_N = N / 2;
   localparam int PW     = $clog2(PHASES);

   state_t                state_q, state_d;
   mode_t                 mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]         p_q, p_d;
   logic [LOGN-1:0]       stage_q, stage_d;

   logic                  last_b, last_p, last_stage, in_run;
   logic [ADDR_WIDTH-1:0] gen_a, gen_b, gen_tw;

   assign last_b     = (b_q == ADDR_WIDTH'(HALF_N - 1));
   assign last_p     = (p_q == PW'(PHASES - 1));
   assign last_stage = (mode_q == INV) ? (stage_q == LOGN'(LOGN - 1)) : (stage_q == '0);
   assign in_run     = (state_q == COMPUTE) || (state_q == SCALE);

   ntt_addr_gen #(
      .N          (N),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .stage        (stage_q),
      .b            (b_q),
      .scale        (state_q == SCALE),
      .addr_a       (gen_a),
      .addr_b       (gen_b),
      .twiddle_addr (gen_tw)
   );

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= FWD;
         b_q     <= '0;
         p_q     <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         b_q     <= b_d;
         p_q     <= p_d;
         stage_q <= stage_d;
      end
   end

   // Next-state: abort wins over everything, stall freezes the whole walk.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      b_d     = b_q;
      p_d     = p_q;
      stage_d = stage_q;
      if (abort) begin
         state_d = IDLE;
         b_d     = '0;
         p_d     = '0;
         stage_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mode_d  = inverse ? INV : FWD;
                  b_d     = '0;
                  p_d     = '0;
                  stage_d = inverse ? '0 : LOGN'(LOGN - 1);
                  state_d = COMPUTE;
               end
            end
            COMPUTE, SCALE: begin
               if (!stall) begin
                  if (!last_p) begin
                     p_d = p_q + PW'(1);
                  end else begin
                     p_d = '0;
                     if (!last_b) begin
                        b_d = b_q + ADDR_WIDTH'(1);
                     end else begin
                        b_d = '0;
                        if (state_q == SCALE) begin
                           state_d = DONE;
                        end else if (last_stage) begin
                           state_d = (mode_q == INV) ? SCALE : DONE;
                        end else if (mode_q == INV) begin
                           stage_d = stage_q + LOGN'(1);
                        end else begin
                           stage_d = stage_q - LOGN'(1);
                        end
                     end
                  end
               end
            end
            DONE: begin
               if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs: addresses are only driven during a run so idle/reset reads back all zeros.
   always_comb begin
      busy            = in_run;
      done            = (state_q == DONE);
      ram_re          = in_run;
      ram_we          = in_run && last_p && !stall;
      butterfly_valid = (state_q == COMPUTE) && (p_q == PW'(PHASES - 2)) && !stall;
      scale_en        = (state_q == SCALE);
      stage_o         = stage_q;
      ram_addr_a      = in_run ? gen_a  : '0;
      ram_addr_b      = in_run ? gen_b  : '0;
      twiddle_addr    = in_run ? gen_tw : '0;
   end

endmodule

// File: tb/tb_ntt_control_cfg.sv
// Directed bench for ntt_control_cfg with N=8, N=16 and N=256 instances.
module tb_ntt_control_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   // N=8 instance
   logic st8, inv8, sl8, ab8, busy8, done8, re8, we8, bv8, sc8;
   logic [2:0] a8, b8, tw8, stg8;
   // N=16 instance
   logic st16, inv16, sl16, ab16, busy16, done16, re16, we16, bv16, sc16;
   logic [3:0] a16, b16, tw16, stg16;
   // N=256 instance
   logic st256, inv256, sl256, ab256, busy256, done256, re256, we256, bv256, sc256;
   logic [7:0] a256, b256, tw256, stg256;

   ntt_control_cfg #(.N(8), .PHASES(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .inverse(inv8), .stall(sl8), .abort(ab8),
      .busy(busy8), .done(done8), .ram_addr_a(a8), .ram_addr_b(b8), .ram_re(re8),
      .ram_we(we8), .twiddle_addr(tw8), .butterfly_valid(bv8), .scale_en(sc8), .stage_o(stg8));

   ntt_control_cfg #(.N(16), .PHASES(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(st16), .inverse(inv16), .stall(sl16), .abort(ab16),
      .busy(busy16), .done(done16), .ram_addr_a(a16), .ram_addr_b(b16), .ram_re(re16),
      .ram_we(we16), .twiddle_addr(tw16), .butterfly_valid(bv16), .scale_en(sc16), .stage_o(stg16));

   ntt_control_cfg #(.N(256), .PHASES(4)) dut256 (
      .clk(clk), .rst_n(rst_n), .start(st256), .inverse(inv256), .stall(sl256), .abort(ab256),
      .busy(busy256), .done(done256), .ram_addr_a(a256), .ram_addr_b(b256), .ram_re(re256),
      .ram_we(we256), .twiddle_addr(tw256), .butterfly_valid(bv256), .scale_en(sc256), .stage_o(stg256));

   // Observation mux: sel picks which instance the checks look at.
   int sel;
   logic m_busy, m_done, m_re, m_we, m_bv, m_sc;
   logic [7:0] m_a, m_b, m_tw, m_stage;

   always_comb begin
      m_busy = 1'b0; m_done = 1'b0; m_re = 1'b0; m_we = 1'b0; m_bv = 1'b0; m_sc = 1'b0;
      m_a = '0; m_b = '0; m_tw = '0; m_stage = '0;
      case (sel)
         8: begin
            m_busy = busy8; m_done = done8; m_re = re8; m_we = we8; m_bv = bv8; m_sc = sc8;
            m_a = 8'(a8); m_b = 8'(b8); m_tw = 8'(tw8); m_stage = 8'(stg8);
         end
         16: begin
            m_busy = busy16; m_done = done16; m_re = re16; m_we = we16; m_bv = bv16; m_sc = sc16;
            m_a = 8'(a16); m_b = 8'(b16); m_tw = 8'(tw16); m_stage = 8'(stg16);
         end
         default: begin
            m_busy = busy256; m_done = done256; m_re = re256; m_we = we256; m_bv = bv256; m_sc = sc256;
            m_a = a256; m_b = b256; m_tw = tw256; m_stage = stg256;
         end
      endcase
   end

   // Run accumulators
   int acc_b, acc_w, acc_s, acc_first;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      acc_b = 0; acc_w = 0; acc_s = 0; acc_first = -1;
   endtask

   // Advance up to n busy cycles, tallying busy, write and scale cycles.
   task automatic measure(input int n);
      int lim;
      lim = acc_b + n;
      while (m_busy && acc_b < lim) begin
         if (m_we) acc_w++;
         if (m_sc) begin
            if (acc_first < 0) acc_first = acc_b;
            acc_s++;
         end
         acc_b++;
         tick();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(m_busy),  0);
      chk({tag, "_done"},  32'(m_done),  0);
      chk({tag, "_re"},    32'(m_re),    0);
      chk({tag, "_we"},    32'(m_we),    0);
      chk({tag, "_bv"},    32'(m_bv),    0);
      chk({tag, "_sc"},    32'(m_sc),    0);
      chk({tag, "_a"},     32'(m_a),     0);
      chk({tag, "_b"},     32'(m_b),     0);
      chk({tag, "_tw"},    32'(m_tw),    0);
      chk({tag, "_stage"}, 32'(m_stage), 0);
   endtask

   logic [7:0] fa, fb, ftw, fst;

   initial begin
      rst_n = 1'b0;
      {st8, inv8, sl8, ab8}         = '0;
      {st16, inv16, sl16, ab16}     = '0;
      {st256, inv256, sl256, ab256} = '0;
      sel = 8;
      clr();
      #2;
      chk_all_zero("rst8");
      sel = 256; #1;
      chk_all_zero("rst256");
      tick();
      rst_n = 1'b1;
      tick();

      // N=8 forward: first/last pair addresses and 48-cycle run
      sel = 8; #1;
      st8 = 1'b1; inv8 = 1'b0;
      tick();
      st8 = 1'b0;
      clr();
      chk("f8_busy", 32'(m_busy), 1);
      chk("f8_re", 32'(m_re), 1);
      chk("f8_stage0", 32'(m_stage), 2);
      chk("f8_a0", 32'(m_a), 0);
      chk("f8_b0", 32'(m_b), 4);
      chk("f8_tw0", 32'(m_tw), 0);
      measure(44);
      chk("f8_stage_last", 32'(m_stage), 0);
      chk("f8_a_last", 32'(m_a), 6);
      chk("f8_b_last", 32'(m_b), 7);
      chk("f8_tw_last", 32'(m_tw), 6);
      measure(1000);
      chk("f8_len", 32'(acc_b), 48);
      chk("f8_we", 32'(acc_w), 12);
      chk("f8_scale", 32'(acc_s), 0);
      chk("f8_done", 32'(m_done), 1);
      tick();
      chk("f8_idle", 32'(m_done), 0);

      // N=8 forward with a 5-cycle stall at stage 1, b=2, p=1
      st8 = 1'b1;
      tick();
      st8 = 1'b0;
      clr();
      measure(25);
      sl8 = 1'b1; #1;
      chk("st_stage", 32'(m_stage), 1);
      chk("st_a", 32'(m_a), 4);
      chk("st_b", 32'(m_b), 6);
      chk("st_tw", 32'(m_tw), 2);
      fa = m_a; fb = m_b; ftw = m_tw; fst = m_stage;
      for (int i = 0; i < 5; i++) begin
         chk("st_frz_a", 32'(m_a), 32'(fa));
         chk("st_frz_b", 32'(m_b), 32'(fb));
         chk("st_frz_tw", 32'(m_tw), 32'(ftw));
         chk("st_frz_stage", 32'(m_stage), 32'(fst));
         chk("st_frz_we", 32'(m_we), 0);
         chk("st_frz_bv", 32'(m_bv), 0);
         acc_b++;
         tick();
      end
      sl8 = 1'b0; #1;
      measure(1000);
      chk("st_len", 32'(acc_b), 53);
      chk("st_done", 32'(m_done), 1);
      tick();

      // Start held through DONE, then an inverse run with stall masking
      st8 = 1'b1; inv8 = 1'b0;
      tick();
      clr();
      measure(1000);
      chk("hold_len", 32'(acc_b), 48);
      for (int i = 0; i < 3; i++) begin
         chk("hold_done", 32'(m_done), 1);
         chk("hold_busy", 32'(m_busy), 0);
         tick();
      end
      st8 = 1'b0;
      tick();
      chk("hold_idle_done", 32'(m_done), 0);
      chk("hold_idle_busy", 32'(m_busy), 0);
      st8 = 1'b1; inv8 = 1'b1;
      tick();
      st8 = 1'b0; inv8 = 1'b0;
      clr();
      chk("i8_stage0", 32'(m_stage), 0);
      chk("i8_a0", 32'(m_a), 0);
      chk("i8_b0", 32'(m_b), 1);
      chk("i8_tw0", 32'(m_tw), 3);
      measure(2);
      chk("i8_bv", 32'(m_bv), 1);
      sl8 = 1'b1; #1;
      chk("i8_bv_masked", 32'(m_bv), 0);
      acc_b++;
      tick();
      sl8 = 1'b0; #1;
      chk("i8_bv_again", 32'(m_bv), 1);
      measure(1);
      chk("i8_we", 32'(m_we), 1);
      sl8 = 1'b1; #1;
      chk("i8_we_masked", 32'(m_we), 0);
      acc_b++;
      tick();
      sl8 = 1'b0; #1;
      measure(1000);
      chk("i8_len", 32'(acc_b), 66);
      chk("i8_we_cnt", 32'(acc_w), 16);
      chk("i8_scale", 32'(acc_s), 16);
      chk("i8_scale_tail", 32'(acc_b - acc_first), 16);
      chk("i8_done", 32'(m_done), 1);
      tick();

      // N=16 inverse with an ignored start, then abort at stage 2
      sel = 16; #1;
      st16 = 1'b1; inv16 = 1'b1;
      tick();
      st16 = 1'b0; inv16 = 1'b0;
      repeat (10) tick();
      st16 = 1'b1;
      tick();
      st16 = 1'b0;
      repeat (55) tick();
      chk("ab_busy", 32'(m_busy), 1);
      chk("ab_stage", 32'(m_stage), 2);
      chk("ab_a", 32'(m_a), 0);
      chk("ab_b", 32'(m_b), 4);
      chk("ab_tw", 32'(m_tw), 1);
      ab16 = 1'b1;
      tick();
      ab16 = 1'b0; #1;
      chk("ab_idle_busy", 32'(m_busy), 0);
      chk("ab_idle_we", 32'(m_we), 0);
      chk("ab_idle_re", 32'(m_re), 0);
      chk("ab_idle_done", 32'(m_done), 0);
      chk("ab_idle_stage", 32'(m_stage), 0);
      tick();
      chk("ab_stay_idle", 32'(m_busy), 0);
      st16 = 1'b1;
      tick();
      st16 = 1'b0;
      clr();
      chk("f16_stage0", 32'(m_stage), 3);
      measure(1000);
      chk("f16_len", 32'(acc_b), 128);
      chk("f16_scale", 32'(acc_s), 0);
      chk("f16_done", 32'(m_done), 1);
      tick();

      // N=256 inverse full run
      sel = 256; #1;
      st256 = 1'b1; inv256 = 1'b1;
      tick();
      st256 = 1'b0; inv256 = 1'b0;
      clr();
      measure(10000);
      chk("i256_len", 32'(acc_b), 4608);
      chk("i256_we", 32'(acc_w), 1152);
      chk("i256_scale", 32'(acc_s), 512);
      chk("i256_scale_tail", 32'(acc_b - acc_first), 512);
      chk("i256_done", 32'(m_done), 1);
      tick();

      // N=256 inverse, reset asserted during SCALE
      st256 = 1'b1; inv256 = 1'b1;
      tick();
      st256 = 1'b0; inv256 = 1'b0;
      clr();
      measure(4100);
      chk("r_in_scale", 32'(m_sc), 1);
      rst_n = 1'b0; #1;
      chk_all_zero("r_mid");
      clr();
      for (int i = 0; i < 2; i++) begin
         tick();
         if (m_we) acc_w++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_we) acc_w++;
         if (m_busy) acc_b++;
      end
      chk("r_no_we", 32'(acc_w), 0);
      chk("r_no_busy", 32'(acc_b), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL timeout: observed still running expected finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/ntt_control_cfg.md
NTT_CONTROL_CFG -- requirements
Module: ntt_control_cfg

Interface
REQ-001 SHALL have parameter N, default 256, meaning transform length; power of two, 4 <= N <= 4096.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(N), meaning the coefficient and twiddle address width.
REQ-003 SHALL have parameter PHASES, default 4, meaning cycles per butterfly slot; PHASES >= 3.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: run request.
REQ-007 SHALL have port inverse, input, 1 bit: mode, sampled with start; 0 = forward Cooley-Tukey, 1 = inverse Gentleman-Sande plus scale pass.
REQ-008 SHALL have port stall, input, 1 bit: freeze sequencing.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-010 SHALL have ports busy and done, outputs, 1 bit each: status.
REQ-011 SHALL have ports ram_addr_a and ram_addr_b, outputs, ADDR_WIDTH bits each: pair addresses.
REQ-012 SHALL have ports ram_re and ram_we, outputs, 1 bit each: read enable and write enable for both ports.
REQ-013 SHALL have port twiddle_addr, output, ADDR_WIDTH bits: twiddle ROM address.
REQ-014 SHALL have port butterfly_valid, output, 1 bit: butterfly operands valid.
REQ-015 SHALL have port scale_en, output, 1 bit: datapath multiplies by N^-1 instead of a butterfly.
REQ-016 SHALL have port stage_o, output, $clog2(N) bits: current stage index, for debug.

Function
REQ-017 SHALL implement states IDLE, COMPUTE, SCALE and DONE.
REQ-018 In IDLE, when start=1 and abort=0, the FSM SHALL latch inverse into mode_q, clear pair counter b and phase counter p, set the stage, and go to COMPUTE.
REQ-019 The first stage SHALL be LOGN-1 in forward mode and 0 in inverse mode.
REQ-020 The pass sequence SHALL run stages LOGN-1 down to 0 in forward mode and 0 up to LOGN-1 in inverse mode.
REQ-021 Within each stage, b SHALL count 0..N/2-1, and p SHALL count 0..PHASES-1 for each b.
REQ-022 Address generation for stage s SHALL be: half = 2^s, group = b>>s, pos = b & (half-1), ram_addr_a = group*2*half + pos, ram_addr_b = ram_addr_a + half.
REQ-023 twiddle_addr SHALL equal 2^(LOGN-1-s) - 1 + group, truncated to ADDR_WIDTH bits.
REQ-024 In COMPUTE and SCALE: ram_re = 1; butterfly_valid = 1 only in COMPUTE with p=PHASES-2; ram_we = 1 only at p=PHASES-1.
REQ-025 Both butterfly_valid and ram_we SHALL be masked by stall.
REQ-026 When the last stage ends (b=N/2-1, p=PHASES-1), the FSM SHALL go to SCALE if mode_q=1, otherwise to DONE.
REQ-027 SCALE SHALL iterate b=0..N/2-1 with ram_addr_a=2b, ram_addr_b=2b+1 and scale_en=1 for the whole state.
REQ-028 In SCALE, twiddle_addr SHALL be 0 and butterfly_valid SHALL be 0.
REQ-029 SCALE SHALL go to DONE after b=N/2-1, p=PHASES-1.
REQ-030 While stall=1, the state, b, p and stage SHALL hold, and the addresses SHALL stay stable.
REQ-031 Abort SHALL have priority over stall and start: abort=1 in any state forces IDLE on the next edge and clears the counters.
REQ-032 A start pulse arriving during COMPUTE or SCALE SHALL be ignored, and mode_q SHALL be unchanged.
REQ-033 In DONE, the FSM SHALL hold done=1 until start=0, then go to IDLE.
REQ-034 A start held high through DONE SHALL NOT retrigger a run.
REQ-035 busy SHALL equal (state is COMPUTE or SCALE); done SHALL equal (state is DONE).
REQ-036 Run length with no stall SHALL be (N/2)*PHASES*LOGN cycles in forward mode, plus (N/2)*PHASES cycles in inverse mode.
REQ-037 All arithmetic SHALL be unsigned at ADDR_WIDTH bits; the stage index SHALL never wrap past 0 or past LOGN-1.

Reset
REQ-038 On rst_n=0, the block SHALL enter IDLE asynchronously with stage, b, p and mode_q cleared.
REQ-039 During reset, all outputs SHALL be 0: busy, done, ram_re, ram_we, butterfly_valid, scale_en, both addresses, twiddle_addr and stage_o.
REQ-040 Reset asserted mid-run SHALL discard the run; no write SHALL occur after the reset edge.

Structure
REQ-041 Package ntt_ctrl_pkg SHALL hold the state_t enum {IDLE, COMPUTE, SCALE, DONE} and the mode_t enum {FWD, INV}.
REQ-042 Address and twiddle generation (REQ-022, REQ-023, REQ-027) SHALL be placed in a combinational sub-module ntt_addr_gen.
REQ-043 ntt_addr_gen SHALL be parametrised by N and ADDR_WIDTH; the FSM and counters SHALL stay in ntt_control_cfg.

Verification
REQ-044 Bench SHALL cover: N=8, forward, PHASES=4, start pulse -> stage 2, b=0 gives addr 0/4, twiddle 0; stage 0, b=3 gives addr 6/7, twiddle 6; busy high 48 cycles; then done=1.
REQ-045 Bench SHALL cover: N=256, inverse -> busy high 4608 cycles; scale_en high for the final 512 of them; 1152 ram_we pulses in total.
REQ-046 Bench SHALL cover: N=8, forward, with stall=1 for 5 cycles at stage 1, b=2, p=1 -> outputs frozen during the stall; busy lasts 53 cycles; no ram_we or butterfly_valid while stalled.
REQ-047 Bench SHALL cover: N=16, inverse, with abort at stage 2 -> IDLE on the next cycle with busy=0 and ram_we=0; a following forward start runs a full 128 cycles.
REQ-048 Bench SHALL cover: start held high through DONE -> done stays 1 and no second run occurs; start low -> IDLE; a new pulse with inverse=1 runs inverse.
REQ-049 Bench SHALL cover: rst_n asserted mid-SCALE -> all outputs 0 immediately; no ram_we after the reset edge.
